apb_master_arb: RTL and testbench



---
 rtl/apb_arb_pkg.sv | 22 ++
 rtl/apb_rr_arbiter.sv | 30 +++
 rtl/apb_master_arb.sv | 128 ++++++++++++
 tb/tb_apb_master_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the multi-requester APB master.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int ID_W_MAX    = 3;
  localparam int RDATA_W_MAX = 32;

  // Widest-case response record; users slice down to their own widths.
  typedef struct packed {
    logic [ID_W_MAX-1:0]    id;
    logic [RDATA_W_MAX-1:0] rdata;
    logic                   err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_vld
);
  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (en && !gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// N-requester APB master: round-robin grant, SETUP/ACCESS sequencing, response return.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles.
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                         pclk,
  input  logic                         prst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic                         pread,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W-1:0]            prdata,
  input  logic                         pready,
  input  logic                         pslverr
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;
  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;

  apb_state_t         state;
  logic [IW-1:0]      ptr, cur_id, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_vld, arb_en, done, tmo;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  // Abort on the wait cycle that would bring the count to TIMEOUT; pready wins.
  assign tmo = !pready && (wait_cnt == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  assign done   = (state == ACCESS) && (pready || tmo);
  assign arb_en = (state == IDLE) || done;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign req_ready = prst ? '0 : gnt;
  assign pread     = psel & ~pwrite;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_id    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: ;
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (done) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            rsp_err   <= pready ? pslverr : 1'b1;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
      // A grant overrides the completion path so back-to-back keeps psel high.
      if (gnt_vld) begin
        state   <= SETUP;
        psel    <= 1'b1;
        penable <= 1'b0;
        paddr   <= addr_a[gnt_idx];
        pwdata  <= wdata_a[gnt_idx];
        pwrite  <= req_write[gnt_idx];
        cur_id  <= gnt_idx;
        ptr     <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed plus randomized bench for apb_master_arb against a queue-based reference model.
module tb_apb_master_arb;
  import apb_arb_pkg::*;

  localparam int N = 4, AW = 8, DW = 8, TMO = 4;

  logic          pclk = 1'b0;
  logic          prst;
  logic [N-1:0]  req_valid, req_write, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pread, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic [35:0]   outs;

  int errors = 0, checks = 0;

  always #5 pclk = ~pclk;

  apb_master_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pread(pread),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  assign outs = {psel, penable, pwrite, pread, paddr, pwdata,
                 rsp_valid, rsp_id, rsp_rdata, rsp_err, req_ready};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: granted-but-unfinished transfers and expected responses.
  typedef struct {
    int            id;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_t;

  gnt_t     gq[$];
  apb_rsp_t rq[$];
  int       mptr = 0;

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  int       mw;
  gnt_t     mg, sg;
  apb_rsp_t me, se;

  always @(negedge pclk) begin
    if (prst) begin
      gq.delete(); rq.delete(); mptr = 0;
    end else begin
      if (req_ready != '0) begin
        mw = rr_pick(req_valid, mptr);
        check("grant_onehot", 64'($countones(req_ready)), 64'd1);
        check("grant_idx", 64'(req_ready), 64'(1 << mw));
        if (mw >= 0) begin
          mg.id = mw; mg.write = req_write[mw];
          mg.addr = req_addr[mw*AW +: AW]; mg.wdata = req_wdata[mw*DW +: DW];
          gq.push_back(mg);
          mptr = (mw + 1) % N;
        end
      end
      if (rsp_valid) begin
        if (rq.size() > 0) begin
          me = rq.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(me.id));
          check("rsp_rdata", 64'(rsp_rdata), 64'(me.rdata));
          check("rsp_err", 64'(rsp_err), 64'(me.err));
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (gq.size() > 0) begin
          mg = gq.pop_front();
          check("tmo_rsp", {rsp_id, rsp_rdata, rsp_err}, {2'(mg.id), 8'h00, 1'b1});
        end
`endif
        else check("rsp_spurious", 64'(rsp_valid), 64'd0);
      end
    end
  end

  // Slave model: s_wait pready-low cycles per ACCESS (-1 = never ready).
  int            s_wait = 0, sacc = 0;
  logic          s_err = 1'b0;
  logic [DW-1:0] s_rdata = '0;
  bit            rnd_slave = 1'b0;

  task automatic slave_done;
    if (gq.size() == 0) check("apb_unexpected", 64'(psel), 64'd0);
    else begin
      sg = gq.pop_front();
      check("paddr", 64'(paddr), 64'(sg.addr));
      check("pwrite", 64'(pwrite), 64'(sg.write));
      check("pwdata", 64'(pwdata), 64'(sg.wdata));
      se.id    = 3'(sg.id);
      se.rdata = sg.write ? 32'd0 : 32'(s_rdata);
      se.err   = s_err;
      rq.push_back(se);
    end
  endtask

  initial begin
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(posedge pclk); #1;
      pready = 1'b0; pslverr = 1'b0; prdata = 8'($urandom);
      if (psel && penable) begin
        if (sacc == 0 && rnd_slave) begin
          s_wait  = $urandom_range(0, 2);
          s_err   = ($urandom_range(0, 3) == 0);
          s_rdata = 8'($urandom);
        end
        if (sacc == s_wait) begin
          pready = 1'b1; pslverr = s_err; prdata = s_rdata;
          slave_done();
        end else if (rnd_slave) pslverr = 1'($urandom);
        sacc++;
      end else sacc = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the end of the sequence");
    $fatal(1);
  end

  task automatic nxt;
    @(posedge pclk); #1;
  endtask

  task automatic smp;
    @(negedge pclk);
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
  endtask

  int            acc, n, first, last, idle, gi;
  int            order[8];
  logic [N-1:0]  acc_mask;

  initial begin
    prst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge pclk);
    smp; check("reset_outputs", 64'(outs), 64'd0);
    nxt; prst = 1'b0;

    // single write, zero wait
    s_wait = 0; s_err = 1'b0;
    nxt; set_req(2, 1'b1, 8'h3C, 8'hA5);
    smp; check("t1_ready", 64'(req_ready), 64'(4'b0100));
    nxt; req_valid = '0;
    smp; check("t1_setup", {psel, penable, pwrite, pread, paddr, pwdata}, {4'b1010, 8'h3C, 8'hA5});
    nxt; smp; check("t1_access", {psel, penable}, 2'b11);
    nxt; smp; check("t1_rsp", {psel, rsp_valid, rsp_id, rsp_err, rsp_rdata}, {2'b01, 2'd2, 1'b0, 8'h00});
    nxt; smp; check("t1_rsp_pulse", 64'(rsp_valid), 64'd0);

    // read with three wait states
    s_wait = 3; s_rdata = 8'h5A;
    nxt; set_req(0, 1'b0, 8'h10, 8'h00);
    smp; check("t2_ready", 64'(req_ready), 64'(4'b0001));
    nxt; req_valid = '0;
    smp; check("t2_setup", {psel, penable, pread, paddr}, {3'b101, 8'h10});
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      nxt; smp;
      if (psel && penable) acc++; else break;
    end
    check("t2_access_len", 64'(acc), 64'd4);
    check("t2_rsp", {rsp_valid, rsp_id, rsp_err, rsp_rdata}, {1'b1, 2'd0, 1'b0, 8'h5A});

    // slave error on a write to the top address
    s_wait = 0; s_err = 1'b1;
    nxt; set_req(3, 1'b1, 8'hFF, 8'h3C);
    smp; check("t3_ready", 64'(req_ready), 64'(4'b1000));
    nxt; req_valid = '0;
    nxt; nxt;
    smp; check("t3_rsp", {rsp_valid, rsp_id, rsp_err}, {1'b1, 2'd3, 1'b1});
    s_err = 1'b0;

    // all four requesting: fair rotation, no bubbles
    nxt;
    for (int i = 0; i < N; i++) set_req(i, 1'(i % 2), 8'(8'h40 + i), 8'(8'h80 + i));
    n = 0; first = 0; last = 0; idle = 0;
    for (int c = 0; c < 100 && n < 8; c++) begin
      smp;
      if (n > 0 && !psel) idle++;
      if (req_ready != '0) begin
        gi = -1;
        for (int k = 0; k < N; k++) if (req_ready[k]) gi = k;
        order[n] = gi;
        if (n == 0) first = c;
        last = c;
        n++;
      end
    end
    nxt; req_valid = '0;
    for (int k = 0; k < 8; k++) check("t4_order", 64'(order[k]), 64'(k % N));
    check("t4_span", 64'(last - first), 64'd14);
    check("t4_idle", 64'(idle), 64'd0);
    for (int c = 0; c < 20; c++) begin
      smp;
      if (!psel) break;
    end

`ifdef APB_ARB_TIMEOUT_EN
    // slave never answers: abort after TMO ACCESS cycles
    s_wait = -1;
    nxt; set_req(2, 1'b0, 8'h22, 8'h00);
    nxt; req_valid = '0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      nxt; smp;
      if (psel && penable) acc++; else break;
    end
    check("t5_len", 64'(acc), 64'(TMO));
    check("t5_rsp", {psel, rsp_valid, rsp_id, rsp_err, rsp_rdata}, {2'b01, 2'd2, 1'b1, 8'h00});
    s_wait = 0;
`endif

    // random traffic against the model
    rnd_slave = 1'b1;
    for (int c = 0; c < 400; c++) begin
      smp; acc_mask = req_ready;
      nxt;
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) begin
          req_valid[i] = 1'b0;
          if ($urandom_range(0, 3) == 0) set_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
      end
    end
    req_valid = '0;
    for (int c = 0; c < 200; c++) begin
      smp;
      if (!psel && gq.size() == 0 && rq.size() == 0) break;
    end
    check("t6_drained", 64'(gq.size() + rq.size()), 64'd0);
    rnd_slave = 1'b0;

    // reset in the middle of ACCESS
    s_wait = -1;
    nxt; set_req(1, 1'b0, 8'h77, 8'h00);
    smp; check("t7_ready", 64'(req_ready), 64'(4'b0010));
    nxt; req_valid = '0;
    nxt; nxt;
    smp; check("t7_in_access", {psel, penable}, 2'b11);
    nxt; prst = 1'b1;
    set_req(0, 1'b1, 8'h01, 8'h11);
    set_req(3, 1'b1, 8'h03, 8'h33);
    #1; check("t7_rst_outputs", 64'(outs), 64'd0);
    s_wait = 0;
    nxt; nxt; prst = 1'b0;
    smp; check("t7_first_grant", {req_ready, rsp_valid}, {4'b0001, 1'b0});
    nxt; req_valid = '0;
    smp; check("t7_no_rsp_setup", 64'(rsp_valid), 64'd0);
    nxt; smp; check("t7_no_rsp_access", 64'(rsp_valid), 64'd0);
    nxt; smp; check("t7_rsp", {rsp_valid, rsp_id, rsp_err}, {1'b1, 2'd0, 1'b0});
    repeat (3) nxt;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
